// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one single-port data memory between the CPU
//               load/store path and a DMA/loader requester. Each side uses a
//               req/ack handshake. Arbitration is round-robin. The DMA side
//               may lock the memory for a burst of up to MAX_BURST
//               back-to-back grants while the CPU is waiting.
//               Each access takes IDLE -> ACCESS -> RESP, so the arbiter
//               completes at most one access every three cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                         clock, all state updates on the rising edge
//   rst_n                       synchronous reset, active low
//   cpu_req/we/addr/wdata       CPU request. req is held until cpu_ack.
//   cpu_ack                     one-cycle completion pulse
//   cpu_rdata                   read data, valid with cpu_ack and held after
//   cpu_stall                   cpu_req & ~cpu_ack
//   dma_req/we/addr/wdata       DMA request. req is held until dma_ack.
//   dma_lock                    request burst ownership, sampled at arbitration
//   dma_ack                     one-cycle completion pulse
//   dma_rdata                   read data, valid with dma_ack and held after
//   mem_en/we/addr/wdata        memory strobe and command, all zero outside
//                               ACCESS
//   mem_rdata                   memory read data, valid one cycle after a read
//                               strobe
//   busy                        arbiter is not idle
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // CPU port
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    // DMA port
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_lock,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    // Memory port
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // Status
    output logic          busy
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam int            c_CW      = $clog2(MAX_BURST + 1);
    localparam logic [c_CW-1:0] c_MAX   = c_CW'(MAX_BURST);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
    localparam logic          c_OWN_CPU = 1'b0;
    localparam logic          c_OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    // r_owner is the owner of the most recent grant. While an access is in
    // flight it selects which ack/rdata to drive. Between accesses it is the
    // round-robin "last owner". Reset value DMA lets the CPU win the first tie.
    logic            r_owner;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [c_CW-1:0] r_burst_cnt;
    logic [DW-1:0]   r_cpu_rdata;
    logic [DW-1:0]   r_dma_rdata;

    logic            w_take;
    logic            w_winner;
    logic            w_access;
    logic            w_resp;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        w_winner = c_OWN_CPU;
        if (cpu_req && dma_req) begin
            // A locked DMA burst keeps ownership until the cap is reached.
            // Otherwise ownership alternates.
            if ((r_owner == c_OWN_DMA) && dma_lock && (r_burst_cnt < c_MAX)) begin
                w_winner = c_OWN_DMA;
            end else begin
                w_winner = ~r_owner;
            end
        end else if (dma_req) begin
            w_winner = c_OWN_DMA;
        end
    end

    // A grant happens only in IDLE. Requests are never looked at in ACCESS or
    // RESP.
    assign w_take = (r_state == S_IDLE) && (cpu_req || dma_req);

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (cpu_req || dma_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= c_OWN_DMA;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_burst_cnt <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_take) begin
                r_owner <= w_winner;
                if (w_winner == c_OWN_DMA) begin
                    r_we    <= dma_we;
                    r_addr  <= dma_addr;
                    r_wdata <= dma_wdata;
                    // An unlocked DMA grant starts a fresh count of one, so a
                    // lock raised later still sees that one grant was used.
                    if (!dma_lock) begin
                        r_burst_cnt <= c_ONE;
                    end else if (r_burst_cnt != c_MAX) begin
                        r_burst_cnt <= r_burst_cnt + c_ONE;
                    end
                end else begin
                    r_we        <= cpu_we;
                    r_addr      <= cpu_addr;
                    r_wdata     <= cpu_wdata;
                    r_burst_cnt <= '0;
                end
            end

            // Capture read data at the end of RESP so it stays on the port
            // after the ack pulse.
            if ((r_state == S_RESP) && !r_we) begin
                if (r_owner == c_OWN_CPU) begin
                    r_cpu_rdata <= mem_rdata;
                end else begin
                    r_dma_rdata <= mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Gate the strobe and the acks with rst_n. A reset that lands in ACCESS
    // then commits no write, and a reset that lands in ACCESS or RESP
    // produces no ack.
    assign w_access  = (r_state == S_ACCESS) && rst_n;
    assign w_resp    = (r_state == S_RESP) && rst_n;

    assign mem_en    = w_access;
    assign mem_we    = w_access && r_we;
    assign mem_addr  = w_access ? r_addr  : '0;
    assign mem_wdata = w_access ? r_wdata : '0;

    assign cpu_ack   = w_resp && (r_owner == c_OWN_CPU);
    assign dma_ack   = w_resp && (r_owner == c_OWN_DMA);

    // Memory data arrives in RESP. It is bypassed to the owner's port so that
    // it appears together with the ack. The register holds it from then on.
    assign cpu_rdata = (cpu_ack && !r_we) ? mem_rdata : r_cpu_rdata;
    assign dma_rdata = (dma_ack && !r_we) ? mem_rdata : r_dma_rdata;

    assign cpu_stall = cpu_req && !cpu_ack;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Testbench for dmem_arbiter. One table row is applied per
//               clock cycle and every output of the arbiter is compared with
//               the values written in the row. Hand-written sequences then
//               cover the locked DMA burst and a reset during a write access.
//               A behavioural single-port memory with synchronous read sits
//               on the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [31:0] A_C = 32'h10;
    localparam logic [31:0] A_D = 32'h20;
    localparam logic [31:0] A_W = 32'h40;
    localparam logic [31:0] D_C = 32'hDEADBEEF;
    localparam logic [31:0] D_D = 32'hCAFEF00D;
    localparam logic [31:0] D_W = 32'h12345678;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_ack;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: a single port with synchronous read.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end
    end

    typedef struct {
        logic        rst;
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [31:0] daddr, dwd;
        logic        dlock;
        logic        e_cack, e_dack, e_en, e_we;
        logic [31:0] e_addr, e_wd;
        logic        e_busy;
        logic        chk_rd;
        logic [31:0] e_crd, e_drd;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic r, input logic cr, input logic cw,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic dl,
                        input logic eca, input logic eda, input logic een, input logic ewe,
                        input logic [31:0] ea, input logic [31:0] ed, input logic eb,
                        input logic ck, input logic [31:0] ecr, input logic [31:0] edr);
        vec_t v;
        v.rst = r; v.creq = cr; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwd = dd; v.dlock = dl;
        v.e_cack = eca; v.e_dack = eda; v.e_en = een; v.e_we = ewe;
        v.e_addr = ea; v.e_wd = ed; v.e_busy = eb;
        v.chk_rd = ck; v.e_crd = ecr; v.e_drd = edr;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle(input logic r);
        rst_n = r;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_lock = 0;
    endtask

    logic own_seq[$];
    logic exp_seq[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        drive_idle(1'b0);
        mem[A_C] = D_C;
        mem[A_D] = D_D;
        mem_rdata = 32'h0;

        // Row columns: rst | cpu req,we,addr,wdata | dma req,we,addr,wdata,lock |
        // expected cack,dack,en,we,addr,wdata,busy | check-rdata, cpu_rdata, dma_rdata
        // Reset held for two cycles, then released while idle
        addv(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,0);
        addv(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,0);
        addv(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,0);
        // CPU read of 0x10: strobe in cycle 1, ack with data in cycle 2
        addv(1, 1,0,A_C,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,0,0);
        addv(1, 1,0,A_C,0, 0,0,0,0,0, 0,0,1,0,A_C,0,1, 1,0,0);
        addv(1, 1,0,A_C,0, 0,0,0,0,0, 1,0,0,0,0,0,1, 1,D_C,0);
        addv(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,D_C,0);
        // Reset again, then both request without a lock: CPU, DMA, CPU
        addv(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 0,0,0,0,0,0,0, 1,0,0);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 0,0,1,0,A_C,0,1, 1,0,0);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 1,0,0,0,0,0,1, 1,D_C,0);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 0,0,0,0,0,0,0, 1,D_C,0);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 0,0,1,0,A_D,0,1, 1,D_C,0);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 0,1,0,0,0,0,1, 1,D_C,D_D);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 0,0,0,0,0,0,0, 1,D_C,D_D);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 0,0,1,0,A_C,0,1, 1,D_C,D_D);
        addv(1, 1,0,A_C,0, 1,0,A_D,0,0, 1,0,0,0,0,0,1, 1,D_C,D_D);
        addv(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,D_C,D_D);
        // DMA writes 0x12345678 to 0x40, then the CPU reads it back
        addv(1, 0,0,0,0, 1,1,A_W,D_W,0, 0,0,0,0,0,0,0, 1,D_C,D_D);
        addv(1, 0,0,0,0, 1,1,A_W,D_W,0, 0,0,1,1,A_W,D_W,1, 1,D_C,D_D);
        addv(1, 0,0,0,0, 1,1,A_W,D_W,0, 0,1,0,0,0,0,1, 1,D_C,D_D);
        addv(1, 1,0,A_W,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,D_C,D_D);
        addv(1, 1,0,A_W,0, 0,0,0,0,0, 0,0,1,0,A_W,0,1, 1,D_C,D_D);
        addv(1, 1,0,A_W,0, 0,0,0,0,0, 1,0,0,0,0,0,1, 1,D_W,D_D);
        addv(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,D_W,D_D);

        foreach (vq[i]) begin
            @(posedge clk); #1;
            rst_n = vq[i].rst;
            cpu_req = vq[i].creq; cpu_we = vq[i].cwe;
            cpu_addr = vq[i].caddr; cpu_wdata = vq[i].cwd;
            dma_req = vq[i].dreq; dma_we = vq[i].dwe;
            dma_addr = vq[i].daddr; dma_wdata = vq[i].dwd; dma_lock = vq[i].dlock;
            @(negedge clk);
            chk($sformatf("row%0d cpu_ack", i),   {31'b0, cpu_ack},   {31'b0, vq[i].e_cack});
            chk($sformatf("row%0d dma_ack", i),   {31'b0, dma_ack},   {31'b0, vq[i].e_dack});
            chk($sformatf("row%0d mem_en", i),    {31'b0, mem_en},    {31'b0, vq[i].e_en});
            chk($sformatf("row%0d mem_we", i),    {31'b0, mem_we},    {31'b0, vq[i].e_we});
            chk($sformatf("row%0d mem_addr", i),  mem_addr,           vq[i].e_addr);
            chk($sformatf("row%0d mem_wdata", i), mem_wdata,          vq[i].e_wd);
            chk($sformatf("row%0d busy", i),      {31'b0, busy},      {31'b0, vq[i].e_busy});
            chk($sformatf("row%0d cpu_stall", i), {31'b0, cpu_stall},
                {31'b0, vq[i].creq & ~vq[i].e_cack});
            if (vq[i].chk_rd) begin
                chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, vq[i].e_crd);
                chk($sformatf("row%0d dma_rdata", i), dma_rdata, vq[i].e_drd);
            end
        end

        // Locked DMA burst with MAX_BURST=4 while the CPU waits. Expected
        // grant order: four DMA, one CPU, four DMA, one CPU.
        @(posedge clk); #1; drive_idle(1'b0);
        @(posedge clk); #1;
        rst_n = 1; cpu_req = 1; cpu_addr = A_C; dma_req = 1; dma_addr = A_D; dma_lock = 1;
        for (int c = 0; c < 60 && own_seq.size() < 10; c++) begin
            @(negedge clk);
            if (cpu_ack && dma_ack) chk("burst both_acks", 32'd1, 32'd0);
            if (cpu_ack) own_seq.push_back(1'b0);
            if (dma_ack) own_seq.push_back(1'b1);
            @(posedge clk); #1;
        end
        chk("burst ack_count", own_seq.size(), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < own_seq.size())
                chk($sformatf("burst grant%0d owner(1=dma)", k), {31'b0, own_seq[k]}, {31'b0, exp_seq[k]});
        end

        // CPU write in flight, reset asserted in its ACCESS cycle
        drive_idle(1'b0);
        @(posedge clk); #1;
        rst_n = 1; cpu_req = 1; cpu_we = 1; cpu_addr = A_C; cpu_wdata = 32'h55AA55AA;
        @(negedge clk);
        chk("rstmid busy_cycle0", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 0;
        @(negedge clk);
        chk("rstmid mem_en", {31'b0, mem_en}, 32'd0);
        chk("rstmid mem_we", {31'b0, mem_we}, 32'd0);
        chk("rstmid cpu_ack_access", {31'b0, cpu_ack}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1; cpu_req = 0; cpu_we = 0;
        @(negedge clk);
        chk("rstmid busy_after", {31'b0, busy}, 32'd0);
        chk("rstmid cpu_ack_after", {31'b0, cpu_ack}, 32'd0);
        @(posedge clk); #1;
        chk("rstmid mem_unchanged", mem[A_C], D_C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
